mod_exp_operand_loader: RTL
===========================

# mod_exp_operand_loader

Upstream front-end for `mod_exp`. It accepts the modulus, exponent and base as a stream of 32-bit words and assembles them into NBITS-wide operand registers. While the modulus streams in, it computes `r_red = 2^m_size - m` word-serially. When all operands are present it fires the single-cycle `enable_p` into `mod_exp`, then holds every operand stable until `done_irq_p` returns.

## Interface
Parameters:
- NBITS, 2048, operand width; must be a multiple of WBITS.
- WBITS, 32, stream word width.
- NWORDS, NBITS/WBITS (64), words per operand; derived, not overridable.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a load; sampled only in IDLE.
- m_size_in  in  12  modulus bit length; sampled with start.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader accepts a word.
- s_data  in  WBITS  stream word.
- m  out  NBITS  modulus to mod_exp.
- exp  out  NBITS  exponent to mod_exp.
- a  out  NBITS  base to mod_exp.
- r_red  out  NBITS  2^m_size - m, masked to m_size bits.
- m_size  out  12  latched m_size_in.
- enable_p  out  1  one-cycle start pulse to mod_exp.
- done_irq_p  in  1  completion pulse from mod_exp.
- busy  out  1  high in every state except IDLE.
- err_p  out  1  one-cycle pulse on a rejected start.

## Operation
- FSM states: IDLE, LOAD_M, LOAD_E, LOAD_A, FIRE, WAIT_DONE.
- Reset values: state IDLE; all operand registers, r_red and m_size are 0; s_ready, enable_p, busy and err_p are 0; word counter is 0; borrow-carry is 1.
- IDLE: on `start`, check m_size_in.
  - Valid range is 1..NBITS: latch m_size, clear m/exp/a/r_red, set carry=1, counter=0, go to LOAD_M.
  - Outside that range: pulse err_p, stay in IDLE, leave the registers unchanged.
- Stream ordering is fixed: NWORDS words of m, then NWORDS of exp, then NWORDS of a. Each operand arrives least-significant word first.
- Word k of the current operand (counter value k) is written to bits [k*WBITS +: WBITS].
- A transfer occurs only when s_valid && s_ready. s_ready is 1 in the three LOAD states and 0 elsewhere.
- The counter increments per transfer. Accepting word NWORDS-1 moves the FSM to the next state and wraps the counter to 0.
- r_red, computed on each m transfer:
  - sum = ~s_data + carry (WBITS+1 bits); carry ← sum[WBITS].
  - r_red word k = sum[WBITS-1:0] AND mask_k.
  - mask_k bit j is 1 iff k*WBITS + j < m_size.
  - Result: m = 0 gives r_red = 0; the 2^NBITS term is dropped.
- Data bits of m at or above m_size are stored unmodified. mod_exp requires them to be 0; the loader does not check this.
- FIRE: enable_p = 1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: outputs are frozen. On done_irq_p, go to IDLE.
- done_irq_p in any state other than WAIT_DONE is ignored.
- start is ignored in every state except IDLE; no err_p is raised.
- rst in any state returns to the full reset values on the next edge, including mid-load and in WAIT_DONE. A partial load is discarded.

## Timing
- start in IDLE at cycle t: s_ready is 1 from cycle t+1.
- A back-to-back stream takes 3*NWORDS transfer cycles.
- Last `a` word accepted at cycle T: enable_p is high in cycle T+1 (state FIRE) and low from T+2.
- Operands and r_red are final by cycle T+1, i.e. stable at the edge where mod_exp samples enable_p.
- done_irq_p high at cycle D in WAIT_DONE: busy is 0 at D+1, and a start at D+1 is accepted.
- Gaps in s_valid only stretch the load; no data is lost or reordered.
- err_p is asserted in cycle t+1 after a rejected start at t.
- Outputs are registered; there are no combinational paths from stream inputs to operand outputs.

## Test plan
- Reset/idle:
  - Hold rst 2 cycles → all outputs 0, state IDLE.
  - Pulse done_irq_p and toggle s_valid in IDLE → no output change.
- Full-width load:
  - Stimulus: m_size_in=2048; m = word0 0x00000005, other words 0; exp = word0 0x3, others 0; a = word0 0x2, others 0.
  - Response: r_red word0 = 0xFFFFFFFB, words 1..63 = 0xFFFFFFFF; exactly one enable_p, one cycle after the 192nd transfer.
- Partial width:
  - Stimulus: m_size_in=32, m word0 = 0xFFFFFFFB.
  - Response: r_red = 5 with all upper bits 0.
  - Repeat with m_size_in=40 → r_red bits 39:32 = 0xFF, bits above 40 = 0.
- Backpressure:
  - Stimulus: random s_valid gaps across the 192 words.
  - Response: operands identical to the gap-free run; enable_p timing relative to the last transfer unchanged.
- Errors and ignores:
  - start with m_size_in=0 → err_p one cycle, busy stays 0.
  - start with m_size_in=2049 → same.
  - start during WAIT_DONE → no effect; busy drops only after done_irq_p.
- Reset mid-operation:
  - Assert rst after 70 transfers (inside LOAD_E) → all registers 0, state IDLE.
  - A following clean load produces correct operands.

Source files
------------

// File: rtl/mod_exp_operand_loader_if.sv
// mod_exp_operand_loader_if: stream, operand and control bundle between the loader and its neighbours.
interface mod_exp_operand_loader_if #(
  parameter int NBITS = 2048,
  parameter int WBITS = 32
);
  logic             start;
  logic [11:0]      m_size_in;
  logic             s_valid;
  logic             s_ready;
  logic [WBITS-1:0] s_data;
  logic [NBITS-1:0] m;
  logic [NBITS-1:0] exp;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] r_red;
  logic [11:0]      m_size;
  logic             enable_p;
  logic             done_irq_p;
  logic             busy;
  logic             err_p;
  modport slave (
    input  start, m_size_in, s_valid, s_data, done_irq_p,
    output s_ready, m, exp, a, r_red, m_size, enable_p, busy, err_p
  );
  modport master (
    output start, m_size_in, s_valid, s_data, done_irq_p,
    input  s_ready, m, exp, a, r_red, m_size, enable_p, busy, err_p
  );
endinterface

// File: rtl/mod_exp_operand_loader.sv
// mod_exp_operand_loader: assembles m/exp/a from a word stream, derives r_red, and launches mod_exp.
module mod_exp_operand_loader #(
  parameter int NBITS = 2048,
  parameter int WBITS = 32
) (
  input logic clk,
  input logic rst,
  mod_exp_operand_loader_if.slave bus
);
  localparam int NWORDS = NBITS / WBITS;
  localparam int CW = $clog2(NWORDS);
  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_E, LOAD_A, FIRE, WAIT_DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [11:0]      m_size_q, m_size_d;
  logic [NBITS-1:0] m_q, m_d, e_q, e_d, a_q, a_d, rr_q, rr_d;
  logic [WBITS:0]   sum;
  logic [WBITS-1:0] mask;
  logic             xfer, last, size_ok;
  assign bus.s_ready  = state_q inside {LOAD_M, LOAD_E, LOAD_A};
  assign bus.busy     = state_q != IDLE;
  assign bus.enable_p = state_q == FIRE;
  assign bus.err_p    = err_q;
  assign bus.m        = m_q;
  assign bus.exp      = e_q;
  assign bus.a        = a_q;
  assign bus.r_red    = rr_q;
  assign bus.m_size   = m_size_q;
  assign xfer    = bus.s_valid && bus.s_ready;
  assign last    = cnt_q == CW'(NWORDS - 1);
  assign size_ok = bus.m_size_in != '0 && int'(bus.m_size_in) <= NBITS;
  // Word-serial two's-complement negation of m; carry chains across words.
  assign sum = {1'b0, ~bus.s_data} + (WBITS + 1)'(carry_q);
  always_comb begin
    mask = '0;
    for (int j = 0; j < WBITS; j++) mask[j] = int'(cnt_q) * WBITS + j < int'(m_size_q);
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    err_d    = 1'b0;
    m_size_d = m_size_q;
    m_d      = m_q;
    e_d      = e_q;
    a_d      = a_q;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (bus.start && size_ok) begin
          state_d  = LOAD_M;
          m_size_d = bus.m_size_in;
          m_d      = '0;
          e_d      = '0;
          a_d      = '0;
          rr_d     = '0;
          carry_d  = 1'b1;
          cnt_d    = '0;
        end
        err_d = bus.start && !size_ok;
      end
      LOAD_M, LOAD_E, LOAD_A: begin
        if (xfer) begin
          cnt_d   = last ? '0 : cnt_q + 1'b1;
          state_d = last ? state_t'(state_q + 3'd1) : state_q;
          if (state_q == LOAD_M) begin
            m_d[cnt_q*WBITS +: WBITS]  = bus.s_data;
            rr_d[cnt_q*WBITS +: WBITS] = sum[WBITS-1:0] & mask;
            carry_d                    = sum[WBITS];
          end
          if (state_q == LOAD_E) e_d[cnt_q*WBITS +: WBITS] = bus.s_data;
          if (state_q == LOAD_A) a_d[cnt_q*WBITS +: WBITS] = bus.s_data;
        end
      end
      FIRE:      state_d = WAIT_DONE;
      WAIT_DONE: state_d = bus.done_irq_p ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      err_q    <= 1'b0;
      m_size_q <= '0;
      m_q      <= '0;
      e_q      <= '0;
      a_q      <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      m_size_q <= m_size_d;
      m_q      <= m_d;
      e_q      <= e_d;
      a_q      <= a_d;
      rr_q     <= rr_d;
    end
  end
endmodule
